regfile_scoreboard: RTL and testbench

REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

---
 rtl/regfile_scoreboard.sv | 95 +++++++++
 tb/tb_regfile_scoreboard.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// Register file with a per-register busy scoreboard: issue marks a register pending,
// write-back stores data and clears it; optional write bypass and hardwired zero register.
module regfile_scoreboard #(
   parameter int WIDTH    = 32,
   parameter int ADDR_W   = 5,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              writeEnable,
   input  logic [ADDR_W-1:0] writeReg,
   input  logic [WIDTH-1:0]  writeData,
   input  logic              issueEnable,
   input  logic [ADDR_W-1:0] issueReg,
   input  logic [ADDR_W-1:0] readReg1,
   input  logic [ADDR_W-1:0] readReg2,
   output logic [WIDTH-1:0]  readData1,
   output logic [WIDTH-1:0]  readData2,
   output logic              busy1,
   output logic              busy2,
   output logic [ADDR_W:0]   pendingCount
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W:0] countOne = 1;

   logic [WIDTH-1:0]  regs [DEPTH];
   logic [DEPTH-1:0]  busy;
   logic              writeValid;
   logic              issueValid;
   logic              countInc;
   logic              countDec;
   logic [ADDR_W-1:0] rdAddr [2];
   logic [WIDTH-1:0]  rdData [2];
   logic              rdBusy [2];

   // Requests aimed at a hardwired zero register are dropped before they touch state.
   // The count only moves when a busy bit actually flips; a same-register issue+write
   // leaves the bit set, so it never counts as a clear.
   always_comb begin
      writeValid = writeEnable;
      issueValid = issueEnable;
      if (ZERO_REG != 0 && writeReg == '0) writeValid = 1'b0;
      if (ZERO_REG != 0 && issueReg == '0) issueValid = 1'b0;
      countInc = issueValid && !busy[issueReg];
      countDec = writeValid && busy[writeReg] && !(issueValid && (issueReg == writeReg));
   end

   // Issue is applied after write so a new producer supersedes the write-back.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
         busy         <= '0;
         pendingCount <= '0;
      end else begin
         if (writeValid) begin
            regs[writeReg] <= writeData;
            busy[writeReg] <= 1'b0;
         end
         if (issueValid) busy[issueReg] <= 1'b1;
         case ({countInc, countDec})
            2'b10:   pendingCount <= pendingCount + countOne;
            2'b01:   pendingCount <= pendingCount - countOne;
            default: pendingCount <= pendingCount;
         endcase
      end
   end

   assign rdAddr[0] = readReg1;
   assign rdAddr[1] = readReg2;

   // Both read ports share one lookup; the zero register check comes last so it
   // overrides any forwarded write.
   always_comb begin
      for (int p = 0; p < 2; p++) begin
         rdData[p] = regs[rdAddr[p]];
         rdBusy[p] = busy[rdAddr[p]];
         if (BYPASS != 0 && writeEnable && (writeReg == rdAddr[p])) begin
            rdData[p] = writeData;
            rdBusy[p] = issueEnable && (issueReg == rdAddr[p]);
         end
         if (ZERO_REG != 0 && rdAddr[p] == '0) begin
            rdData[p] = '0;
            rdBusy[p] = 1'b0;
         end
      end
   end

   assign readData1 = rdData[0];
   assign readData2 = rdData[1];
   assign busy1     = rdBusy[0];
   assign busy2     = rdBusy[1];

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench: dut 0 uses defaults (zero reg, bypass), dut 1 has neither.
// Stimulus pushes expected read results; a negedge monitor pops and compares.
module tb_regfile_scoreboard;

   typedef struct packed {
      logic        rst;
      logic        we;
      logic [4:0]  wr;
      logic [31:0] wd;
      logic        ie;
      logic [4:0]  ir;
      logic [4:0]  r1;
      logic [4:0]  r2;
   } stim_t;

   typedef struct {
      int          dut;
      logic [31:0] d1;
      logic        b1;
      logic [31:0] d2;
      logic        b2;
      logic [5:0]  cnt;
   } exp_t;

   logic        clk;
   stim_t       stimA, stimB;
   logic [31:0] aD1, aD2, bD1, bD2;
   logic        aB1, aB2, bB1, bB2;
   logic [5:0]  aCnt, bCnt;

   exp_t  expQ[$];
   string nameQ[$];
   int    errors = 0;
   int    checks = 0;

   regfile_scoreboard dutA (
      .clk(clk), .rst(stimA.rst),
      .writeEnable(stimA.we), .writeReg(stimA.wr), .writeData(stimA.wd),
      .issueEnable(stimA.ie), .issueReg(stimA.ir),
      .readReg1(stimA.r1), .readReg2(stimA.r2),
      .readData1(aD1), .readData2(aD2), .busy1(aB1), .busy2(aB2),
      .pendingCount(aCnt)
   );

   regfile_scoreboard #(.ZERO_REG(0), .BYPASS(0)) dutB (
      .clk(clk), .rst(stimB.rst),
      .writeEnable(stimB.we), .writeReg(stimB.wr), .writeData(stimB.wd),
      .issueEnable(stimB.ie), .issueReg(stimB.ir),
      .readReg1(stimB.r1), .readReg2(stimB.r2),
      .readData1(bD1), .readData2(bD2), .busy1(bB1), .busy2(bB2),
      .pendingCount(bCnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic stim_t mk(input logic rst, input logic we, input logic [4:0] wr,
                                input logic [31:0] wd, input logic ie, input logic [4:0] ir,
                                input logic [4:0] r1, input logic [4:0] r2);
      stim_t s;
      s.rst = rst; s.we = we; s.wr = wr; s.wd = wd;
      s.ie = ie; s.ir = ir; s.r1 = r1; s.r2 = r2;
      return s;
   endfunction

   // Inputs change 1 time unit after the rising edge; the monitor samples at the falling edge.
   task automatic applyStimulus(input int dut, input stim_t s);
      @(posedge clk);
      #1;
      if (dut == 0) stimA = s;
      else          stimB = s;
   endtask

   task automatic checkOutput(input string name, input int dut, input logic [31:0] d1,
                              input logic b1, input logic [31:0] d2, input logic b2,
                              input logic [5:0] cnt);
      exp_t e;
      e.dut = dut; e.d1 = d1; e.b1 = b1; e.d2 = d2; e.b2 = b2; e.cnt = cnt;
      expQ.push_back(e);
      nameQ.push_back(name);
   endtask

   always @(negedge clk) begin
      while (expQ.size() > 0) begin
         exp_t        e;
         string       n;
         logic [31:0] d1, d2;
         logic        b1, b2;
         logic [5:0]  c;
         e = expQ.pop_front();
         n = nameQ.pop_front();
         if (e.dut == 0) begin d1 = aD1; b1 = aB1; d2 = aD2; b2 = aB2; c = aCnt; end
         else            begin d1 = bD1; b1 = bB1; d2 = bD2; b2 = bB2; c = bCnt; end
         checks++;
         if ({d1, b1, d2, b2, c} !== {e.d1, e.b1, e.d2, e.b2, e.cnt}) begin
            errors++;
            $display("[TB] FAIL %s (dut%0d): got d1=%h b1=%b d2=%h b2=%b cnt=%0d, expected d1=%h b1=%b d2=%h b2=%b cnt=%0d",
                     n, e.dut, d1, b1, d2, b2, c, e.d1, e.b1, e.d2, e.b2, e.cnt);
         end
      end
   end

   initial begin
      stimA = mk(1, 0, 0, 0, 0, 0, 0, 0);
      stimB = mk(1, 0, 0, 0, 0, 0, 0, 0);

      // dut 0: zero register and bypass enabled
      applyStimulus(0, mk(1, 0, 0, 0, 0, 0, 0, 0));
      for (int i = 0; i < 32; i++) begin
         applyStimulus(0, mk(0, 0, 0, 0, 0, 0, 5'(i), 5'(31 - i)));
         checkOutput("resetReadAll", 0, 0, 0, 0, 0, 0);
      end
      applyStimulus(0, mk(0, 1, 5, 32'hDEADBEEF, 0, 0, 5, 5));
      checkOutput("bypassWrite5", 0, 32'hDEADBEEF, 0, 32'hDEADBEEF, 0, 0);
      applyStimulus(0, mk(0, 0, 0, 0, 0, 0, 5, 0));
      checkOutput("readBack5", 0, 32'hDEADBEEF, 0, 0, 0, 0);
      applyStimulus(0, mk(0, 0, 0, 0, 1, 7, 7, 9));
      checkOutput("issue7", 0, 0, 0, 0, 0, 0);
      applyStimulus(0, mk(0, 0, 0, 0, 1, 9, 7, 9));
      checkOutput("issue9", 0, 0, 1, 0, 0, 1);
      applyStimulus(0, mk(0, 0, 0, 0, 1, 7, 7, 9));
      checkOutput("reissue7", 0, 0, 1, 0, 1, 2);
      applyStimulus(0, mk(0, 0, 0, 0, 0, 0, 7, 9));
      checkOutput("countAfterReissue", 0, 0, 1, 0, 1, 2);
      applyStimulus(0, mk(0, 1, 7, 32'h77, 0, 0, 7, 9));
      checkOutput("writeBusy7", 0, 32'h77, 0, 0, 1, 2);
      applyStimulus(0, mk(0, 0, 0, 0, 0, 0, 7, 9));
      checkOutput("after7Cleared", 0, 32'h77, 0, 0, 1, 1);
      applyStimulus(0, mk(0, 0, 0, 0, 1, 3, 3, 9));
      checkOutput("issue3", 0, 0, 0, 0, 1, 1);
      applyStimulus(0, mk(0, 1, 3, 32'h55, 1, 3, 3, 3));
      checkOutput("issueWriteSame3", 0, 32'h55, 1, 32'h55, 1, 2);
      applyStimulus(0, mk(0, 0, 0, 0, 0, 0, 3, 9));
      checkOutput("after3IssueWins", 0, 32'h55, 1, 0, 1, 2);
      applyStimulus(0, mk(0, 1, 0, 32'hFFFFFFFF, 1, 0, 0, 5));
      checkOutput("zeroRegBypass", 0, 0, 0, 32'hDEADBEEF, 0, 2);
      applyStimulus(0, mk(0, 0, 0, 0, 0, 0, 0, 0));
      checkOutput("zeroRegIgnored", 0, 0, 0, 0, 0, 2);
      applyStimulus(0, mk(0, 1, 9, 32'h99, 1, 12, 9, 12));
      checkOutput("writeOneIssueOther", 0, 32'h99, 0, 0, 0, 2);
      applyStimulus(0, mk(0, 0, 0, 0, 0, 0, 9, 12));
      checkOutput("netZeroCount", 0, 32'h99, 0, 0, 1, 2);
      applyStimulus(0, mk(1, 1, 3, 32'hAB, 1, 20, 3, 12));
      applyStimulus(0, mk(0, 0, 0, 0, 0, 0, 3, 20));
      checkOutput("resetMidOp", 0, 0, 0, 0, 0, 0);
      applyStimulus(0, mk(0, 1, 3, 32'h11, 0, 0, 3, 12));
      checkOutput("writeAfterReset", 0, 32'h11, 0, 0, 0, 0);
      applyStimulus(0, mk(0, 0, 0, 0, 0, 0, 3, 12));
      checkOutput("ordinaryWrite", 0, 32'h11, 0, 0, 0, 0);

      // dut 1: register 0 is ordinary, no bypass
      applyStimulus(1, mk(1, 0, 0, 0, 0, 0, 0, 0));
      applyStimulus(1, mk(0, 0, 0, 0, 0, 0, 0, 31));
      checkOutput("resetReadB", 1, 0, 0, 0, 0, 0);
      applyStimulus(1, mk(0, 1, 5, 32'hDEADBEEF, 0, 0, 5, 5));
      checkOutput("noBypassWrite5", 1, 0, 0, 0, 0, 0);
      applyStimulus(1, mk(0, 1, 0, 32'h12345678, 0, 0, 5, 0));
      checkOutput("latency5", 1, 32'hDEADBEEF, 0, 0, 0, 0);
      applyStimulus(1, mk(0, 0, 0, 0, 0, 0, 0, 0));
      checkOutput("reg0Writable", 1, 32'h12345678, 0, 32'h12345678, 0, 0);
      for (int i = 0; i < 32; i++) begin
         logic [31:0] dv;
         dv = (i == 0) ? 32'h12345678 : (i == 5) ? 32'hDEADBEEF : 32'h0;
         applyStimulus(1, mk(0, 0, 0, 0, 1, 5'(i), 5'(i), 5'(i)));
         checkOutput("issueAll", 1, dv, 0, dv, 0, 6'(i));
      end
      applyStimulus(1, mk(0, 0, 0, 0, 0, 0, 0, 31));
      checkOutput("fullCount", 1, 32'h12345678, 1, 0, 1, 32);
      applyStimulus(1, mk(0, 1, 0, 32'hA, 0, 0, 0, 31));
      checkOutput("noBypassBusy", 1, 32'h12345678, 1, 0, 1, 32);
      applyStimulus(1, mk(1, 1, 31, 32'hCAFE, 1, 0, 0, 31));
      checkOutput("readDuringReset", 1, 32'hA, 0, 0, 1, 31);
      applyStimulus(1, mk(0, 0, 0, 0, 0, 0, 31, 0));
      checkOutput("resetDiscardsWrite", 1, 0, 0, 0, 0, 0);

      @(posedge clk);
      @(negedge clk);
      #1;
      if (expQ.size() != 0) begin
         errors++;
         $display("[TB] FAIL drain: %0d expectations left unchecked, required 0", expQ.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
